// File: rtl/delay_slot_arbiter.sv
// Time-shares one WIDTH-bit down-counter among NREQ requesters (round-robin by default).
// Define DELAY_SLOT_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module delay_slot_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   load_val,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [WIDTH-1:0]        count
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT              r_state;
    logic [IDXW-1:0]    r_owner;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_done;
    logic               r_busy;
    logic [WIDTH-1:0]   r_count;

    logic               w_anyReq;
    logic [IDXW-1:0]    w_winner;
    logic [IDXW-1:0]    w_scanIdx;

`ifndef DELAY_SLOT_ARBITER_FIXED_PRIO_EN
    logic [IDXW-1:0]    r_rrPtr;
    logic [IDXW-1:0]    w_nextOwner;

    // Pointer moves just past whoever last held the counter, so it gets lowest priority next time.
    assign w_nextOwner = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);
`endif

    // First requester found scanning upward (modulo NREQ) from the priority start point.
    always_comb begin
        w_anyReq  = 1'b0;
        w_winner  = '0;
        w_scanIdx = '0;
        for (int off = 0; off < NREQ; off++) begin
`ifdef DELAY_SLOT_ARBITER_FIXED_PRIO_EN
            w_scanIdx = IDXW'(off);
`else
            w_scanIdx = IDXW'((int'(r_rrPtr) + off) % NREQ);
`endif
            if (!w_anyReq && req[w_scanIdx]) begin
                w_anyReq = 1'b1;
                w_winner = w_scanIdx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '1;
`ifndef DELAY_SLOT_ARBITER_FIXED_PRIO_EN
            r_rrPtr <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= '0;
                    if (w_anyReq) begin
                        r_owner <= w_winner;
                        r_grant <= NREQ'(1) << w_winner;
                        r_count <= load_val[w_winner*WIDTH +: WIDTH];
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // An abort outranks expiry: a requester that walked away gets no done pulse.
                    if (!req[r_owner]) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`ifndef DELAY_SLOT_ARBITER_FIXED_PRIO_EN
                        r_rrPtr <= w_nextOwner;
`endif
                    end else if (r_count == '0) begin
                        r_grant <= '0;
                        r_done  <= NREQ'(1) << r_owner;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count - WIDTH'(1);
                    end
                end
                DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`ifndef DELAY_SLOT_ARBITER_FIXED_PRIO_EN
                    r_rrPtr <= w_nextOwner;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = r_count;

endmodule

// File: tb/tb_delay_slot_arbiter.sv
// Scoreboard bench for delay_slot_arbiter: a timestamp-level model predicts grant/done/release/abort
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_delay_slot_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] loadVal;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    delay_slot_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (loadVal),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum int {EV_GRANT, EV_DONE, EV_RELEASE, EV_ABORT} evKindT;
    typedef struct {
        evKindT           kind;
        int               cyc;
        logic [NREQ-1:0]  vec;
        logic [WIDTH-1:0] cnt;
        logic             busy;
    } evT;

    evT expQ[$];

    // Requester agents and model timeline (all times are edge numbers)
    bit agActive[NREQ];
    bit agCool[NREQ];
    int agVal[NREQ];
    int agAbortAfter[NREQ];

    int mOwner     = -1;
    int mPtr       = 0;
    int mFreeAt    = 0;
    int mGrantEdge = -10;
    int mDoneEdge  = -10;
    int mAbortEdge = -10;
    int mDropAgent = -1;
    int mDropAt    = -10;
    bit randomMode = 1'b0;

    function automatic logic [NREQ-1:0] onehot(int i);
        return NREQ'(1) << i;
    endfunction

    function automatic void pushEv(evKindT kind, int c, logic [NREQ-1:0] v, int cnt, logic b);
        evT e;
        e.kind = kind;
        e.cyc  = c;
        e.vec  = v;
        e.cnt  = WIDTH'(cnt);
        e.busy = b;
        expQ.push_back(e);
    endfunction

    function automatic void checkOutput(string name, int actual, int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endfunction

    task automatic raiseReq(int i, int v, int abortAfter);
        agActive[i]     = 1'b1;
        agVal[i]        = v;
        agAbortAfter[i] = abortAfter;
    endtask

    // Plans the next edge from the spec timeline: grant at k, done at k+V+1, idle again at k+V+2.
    task automatic applyStimulus();
        int k;
        int w;
        int idx;
        int v;
        int ab;
        k = cyc + 1;
        foreach (agCool[i]) agCool[i] = 1'b0;
        if (k == mDropAt) begin
            agActive[mDropAgent] = 1'b0;
            agCool[mDropAgent]   = 1'b1;
            mDropAt              = -10;
        end
        if (mOwner >= 0 && k == mAbortEdge) begin
            pushEv(EV_ABORT, k, '0, agVal[mOwner] - (mAbortEdge - mGrantEdge - 1), 1'b0);
            agActive[mOwner] = 1'b0;
            agCool[mOwner]   = 1'b1;
            mPtr             = (mOwner + 1) % NREQ;
            mFreeAt          = k + 1;
            mOwner           = -1;
        end else if (mOwner >= 0 && k == mDoneEdge) begin
            pushEv(EV_DONE, k, onehot(mOwner), 0, 1'b1);
            pushEv(EV_RELEASE, k + 1, '0, 0, 1'b0);
            mDropAgent = mOwner;
            mDropAt    = k + 1;
            mPtr       = (mOwner + 1) % NREQ;
            mFreeAt    = k + 2;
            mOwner     = -1;
        end
        if (randomMode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!agActive[i] && !agCool[i] && $urandom_range(7) == 0) begin
                    v  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 12));
                    ab = ($urandom_range(5) == 0) ? int'($urandom_range(1, v + 1)) : 0;
                    raiseReq(i, v, ab);
                end
            end
        end
        if (mOwner < 0 && k >= mFreeAt) begin
            w = -1;
            for (int off = 0; off < NREQ; off++) begin
`ifdef DELAY_SLOT_ARBITER_FIXED_PRIO_EN
                idx = off;
`else
                idx = (mPtr + off) % NREQ;
`endif
                if (w < 0 && agActive[idx]) w = idx;
            end
            if (w >= 0) begin
                mOwner     = w;
                mGrantEdge = k;
                mDoneEdge  = k + agVal[w] + 1;
                mAbortEdge = (agAbortAfter[w] > 0) ? k + agAbortAfter[w] : -10;
                pushEv(EV_GRANT, k, onehot(w), agVal[w], 1'b1);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i] = agActive[i];
            loadVal[i*WIDTH +: WIDTH] = agActive[i] ? WIDTH'(agVal[i]) : WIDTH'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(int n);
        rst = 1'b1;
        expQ.delete();
        for (int i = 0; i < NREQ; i++) begin
            agActive[i]     = 1'b0;
            agCool[i]       = 1'b0;
            agAbortAfter[i] = 0;
        end
        mOwner     = -1;
        mPtr       = 0;
        mDropAt    = -10;
        mAbortEdge = -10;
        mDoneEdge  = -10;
        req        = '0;
        repeat (n) @(posedge clk);
        #1;
        rst     = 1'b0;
        mFreeAt = cyc + 1;
    endtask

    // Monitor: turns output transitions into events and checks them against the queue
    logic [NREQ-1:0] prevGrant = '0;
    logic [NREQ-1:0] prevDone  = '0;
    logic            prevBusy  = 1'b0;

    function automatic void observe(evKindT kind, logic [NREQ-1:0] v);
        evT e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpectedEvent: got kind=%0d cyc=%0d vec=%b cnt=%0d busy=%b, expected none",
                     kind, cyc, v, count, busy);
        end else begin
            e = expQ.pop_front();
            if (kind != e.kind || cyc != e.cyc || v != e.vec || count != e.cnt || busy != e.busy) begin
                miscompares++;
                $display("[TB] FAIL event: got kind=%0d cyc=%0d vec=%b cnt=%0d busy=%b, expected kind=%0d cyc=%0d vec=%b cnt=%0d busy=%b",
                         kind, cyc, v, count, busy, e.kind, e.cyc, e.vec, e.cnt, e.busy);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prevGrant <= '0;
            prevDone  <= '0;
            prevBusy  <= 1'b0;
        end else begin
            vectors++;
            if ((grant & done) != '0 || $countones(grant) > 1) begin
                miscompares++;
                $display("[TB] FAIL grantDoneExclusive: got grant=%b done=%b, expected disjoint one-hot", grant, done);
            end
            if (prevBusy && !busy) observe((prevDone != '0) ? EV_RELEASE : EV_ABORT, grant);
            if (done != '0 && prevDone == '0) observe(EV_DONE, done);
            if (grant != '0 && grant != prevGrant) observe(EV_GRANT, grant);
            prevGrant <= grant;
            prevDone  <= done;
            prevBusy  <= busy;
        end
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        loadVal = '0;
        doReset(2);

        // Reset state after a few quiet cycles
        repeat (3) applyStimulus();
        checkOutput("resetGrant", int'(grant), 0);
        checkOutput("resetDone", int'(done), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetCount", int'(count), 255);

        // Single request, then zero delay
        raiseReq(0, 3, 0);
        repeat (8) applyStimulus();
        raiseReq(2, 0, 0);
        repeat (5) applyStimulus();

        // Fairness from a fresh pointer
        doReset(1);
        for (int i = 0; i < NREQ; i++) raiseReq(i, 2, 0);
        repeat (24) applyStimulus();

        // Abort at count 6 and hold
        raiseReq(1, 10, 5);
        repeat (10) applyStimulus();
        checkOutput("abortHoldCount", int'(count), 6);
        checkOutput("abortHoldBusy", int'(busy), 0);

        // Requester 3 raises during requester 0's DONE cycle
        mDoneEdge = -10;
        raiseReq(0, 2, 0);
        for (int t = 0; t < 20 && (cyc + 1) != (mDoneEdge + 1); t++) applyStimulus();
        raiseReq(3, 4, 0);
        repeat (12) applyStimulus();

        // Reset mid-RUN while count is 5
        raiseReq(0, 20, 0);
        applyStimulus();
        for (int t = 0; t < 30 && cyc != mGrantEdge + 15; t++) applyStimulus();
        checkOutput("preResetCount", int'(count), 5);
        rst = 1'b1;
        #1;
        checkOutput("midResetGrant", int'(grant), 0);
        checkOutput("midResetDone", int'(done), 0);
        checkOutput("midResetBusy", int'(busy), 0);
        checkOutput("midResetCount", int'(count), 255);
        doReset(2);
        repeat (6) applyStimulus();

        // Randomized traffic, then drain
        randomMode = 1'b1;
        repeat (3000) applyStimulus();
        randomMode = 1'b0;
        repeat (120) applyStimulus();
        checkOutput("pendingEvents", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/delay_slot_arbiter.md
# delay_slot_arbiter

Round-robin scheduler that time-shares one WIDTH-bit down-counter between NREQ requesters. Each requester asks for a delay of V cycles. The block grants the counter to one requester at a time, loads V and counts down to zero. It then pulses that requester's done bit and returns to arbitration. It sits in front of the team's N-bit down-counter datapath, so several agents can use one timer without duplicating it.

## Interface
- WIDTH, 8: counter and load-value width in bits.
- NREQ, 4: number of requesters; must be ≥2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  level request per requester; held high until its done pulse or until it aborts.
- load_val  in  NREQ*WIDTH  delay for requester i in bits [i*WIDTH +: WIDTH]; sampled only in the grant cycle.
- grant  out  NREQ  one-hot owner of the counter; all-zero when not in RUN.
- done  out  NREQ  one-cycle pulse to the owner when its delay expires.
- busy  out  1  high in RUN and DONE.
- count  out  WIDTH  current counter value.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- Reset values: state=IDLE, grant=0, done=0, busy=0, count=all-ones (2^WIDTH−1), rr_ptr=0.
- IDLE:
  - No req bit high: count holds.
  - Any req bit high: select the winner. Scan from index rr_ptr upward, modulo NREQ, and take the first req bit that is high.
  - On the next edge: grant=onehot(winner), count=load_val[winner], busy=1, state goes to RUN.
- RUN, each edge:
  - req[owner] low (abort): grant=0, busy=0, state goes to IDLE. No done pulse. count holds. rr_ptr=owner+1 mod NREQ.
  - count==0: state goes to DONE, done[owner]=1, grant=0. busy stays 1.
  - Otherwise: count=count−1.
- DONE: exactly one cycle.
  - done returns to 0, busy=0, rr_ptr=owner+1 mod NREQ, state goes to IDLE.
  - count stays 0 until the next grant.
- A requester drops req in the cycle it samples done high. If req is still high in IDLE, it is treated as a new request.
- Requests other than the owner's are ignored in RUN and DONE. They are re-evaluated in IDLE.
- load_val with value 0 is legal. The owner sees RUN for one cycle, then the done pulse.
- Counter arithmetic is unsigned WIDTH-bit. Decrement never executes at 0, so there is no wrap-around in normal operation.
- rst asserted in any state returns all registers to their reset values immediately. Any in-flight delay is lost and no done pulse is issued.

## Timing
- Grant latency: a req rising before edge k, with the FSM in IDLE, gives grant and count=V after edge k.
- Delay: after the grant edge, done is high after edge k+V+1 and low after edge k+V+2.
- Owner occupancy is V+2 cycles, counting RUN plus DONE.
- Back-to-back service: the next winner can be granted at edge k+V+3, one IDLE cycle after DONE.
- An abort takes effect on the edge where req[owner] is sampled low.

## Configuration
- DELAY_SLOT_ARBITER_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-indexed req bit high in IDLE wins, and rr_ptr is not implemented.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-RUN: hold rst, release it, then run 3 cycles with no req. Expect grant=0, done=0, busy=0 and count=0xFF (WIDTH=8). Then assert rst while count=5 in RUN. Expect all outputs back at their reset values immediately, with no done pulse.
- Single request: req=0001, V=3. Expect grant=0001 for 4 cycles, with count 3,2,1,0. Expect done=0001 for 1 cycle, then busy=0.
- Zero delay: req=0100, V=0. Expect grant=0100 for 1 cycle, then done=0100 on the next cycle.
- Round-robin fairness: req=1111 held continuously, each requester dropping req on its own done, all V=2. Expect grant order 0,1,2,3. With the fixed-priority macro defined, and each requester re-raising req after its done, expect requester 0 granted repeatedly.
- Abort: req=0010, V=10. Drop req[1] when count=6. Expect grant=0 on the next edge, no done pulse, and count frozen at 6.
- Simultaneous events: requester 3 raises req while requester 0 is in DONE, with rr_ptr advancing to 1. Expect requester 3 granted in the following IDLE cycle, and no overlap between the done and grant bits.
